// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // What the consumer sees for one completed request.
  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  // One read-pipeline slot: the raw word plus what is needed to extract the lane later.
  typedef struct packed {
    logic        fault;
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] word;
  } stage_t;

  // A request faults on an illegal size, a misaligned half/word, or an address past the array.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [1:0] off,
                                        input logic       out_of_range);
    logic f;
    f = out_of_range;
    case (size)
      SZ_HALF: f = f | off[0];
      SZ_WORD: f = f | (off != 2'b00);
      SZ_ILL:  f = 1'b1;
      default: f = f;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the load/store unit and the byte-lane data memory.
// Latency: none (wires only).
// Backpressure: req_ready from the memory, rsp_ready from the consumer.
interface dmem_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane handling: load extract/extend and store lane-mask/data replicate.
// Latency: combinational.
// Backpressure: none.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed lane (offset 0 is the most significant) and sign/zero extend it.
  always_comb begin
    ld_byte = ld_word[31:24];
    case (ld_off)
      2'd1:    ld_byte = ld_word[23:16];
      2'd2:    ld_byte = ld_word[15:8];
      2'd3:    ld_byte = ld_word[7:0];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[15:0] : ld_word[31:16];
    ld_data = '0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_uns}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_uns}}, ld_half};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

  // Replicate the right-justified store data across lanes; the mask selects which lanes land.
  always_comb begin
    st_mask = 4'b0000;
    st_word = '0;
    case (st_size)
      SZ_BYTE: begin
        st_mask = 4'b1000 >> st_off;
        st_word = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_mask = st_off[1] ? 4'b0011 : 4'b1100;
        st_word = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_mask = 4'b1111;
        st_word = st_wdata;
      end
      default: begin
        st_mask = 4'b0000;
        st_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with sized big-endian loads/stores and fault reporting.
// Latency: READ_LAT cycles from request accept to response.
// Backpressure: an unaccepted response freezes the whole pipeline and drops req_ready.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_bytelane_if.slave bus,
  output logic [7:0]     fault_count
);

  localparam int AW = $clog2(DEPTH_WORDS) + 2;

  logic [31:0] mem [DEPTH_WORDS];
  stage_t      stg [READ_LAT];
  logic        vld [READ_LAT];

  logic          stall;
  logic          accept;
  logic          oor;
  logic          req_fault;
  logic [AW-3:0] idx;
  logic [31:0]   ld_data;
  logic [3:0]    st_mask;
  logic [31:0]   st_word;
  rsp_t          rsp;

  assign stall         = vld[READ_LAT-1] && !bus.rsp_ready;
  assign bus.req_ready = !stall && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign oor           = (bus.req_addr >> AW) != 32'd0;
  assign idx           = bus.req_addr[AW-1:2];
  assign req_fault     = access_fault(bus.req_size, bus.req_addr[1:0], oor);

  // Load side works on the output stage; store side works on the incoming request.
  dmem_lane_align u_align (
    .ld_size  (stg[READ_LAT-1].size),
    .ld_uns   (stg[READ_LAT-1].uns),
    .ld_off   (stg[READ_LAT-1].off),
    .ld_word  (stg[READ_LAT-1].word),
    .ld_data  (ld_data),
    .st_size  (bus.req_size),
    .st_off   (bus.req_addr[1:0]),
    .st_wdata (bus.req_wdata),
    .st_mask  (st_mask),
    .st_word  (st_word)
  );

  // Commit only the addressed lanes of a clean store at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_fault) begin
      for (int l = 0; l < 4; l++) begin
        if (st_mask[l]) mem[idx][8*l +: 8] <= st_word[8*l +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures the word at accept, everything shifts unless stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld[i] <= 1'b0;
        stg[i] <= '0;
      end
    end else if (!stall) begin
      vld[0]         <= accept;
      stg[0].fault   <= req_fault;
      stg[0].is_load <= !bus.req_we;
      stg[0].size    <= bus.req_size;
      stg[0].uns     <= bus.req_unsigned;
      stg[0].off     <= bus.req_addr[1:0];
      stg[0].word    <= mem[idx];
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
        stg[i] <= stg[i-1];
      end
    end
  end

  // Stores and faults return zero data; only clean loads carry the extracted lane.
  always_comb begin
    rsp = '0;
    if (vld[READ_LAT-1]) begin
      rsp.fault = stg[READ_LAT-1].fault;
      if (stg[READ_LAT-1].is_load && !stg[READ_LAT-1].fault) rsp.rdata = ld_data;
    end
  end

  assign bus.rsp_valid = vld[READ_LAT-1];
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_fault = rsp.fault;

  // Saturating count of accepted faulted requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_count <= 8'd0;
    end else if (accept && req_fault && fault_count != 8'hFF) begin
      fault_count <= fault_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane against a byte-array reference model.
// Latency: checks READ_LAT=3 response timing where the pipeline is not stalled.
// Backpressure: exercises rsp_ready stalls and expects req_ready to drop.
module tb_dmem_bytelane;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int BYTES = DEPTH * 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fault_count;

  dmem_bytelane_if bus ();

  dmem_bytelane #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       got_q[$];
  logic [7:0] mm [BYTES];

  // Record every response that will be taken at the coming edge, tagged with that edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.rsp_valid && bus.rsp_ready)
      got_q.push_back('{rdata: bus.rsp_rdata, fault: bus.rsp_fault, cyc: cyc + 1});
  end

  function automatic logic m_fault(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= BYTES);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input int a);
    int     n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | longint'(mm[a + i]);
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void m_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) mm[a + i] = 8'(wd >> (8 * (n - 1 - i)));
  endfunction

  // Present one request from a negedge and hold it until accepted; log the model's answer.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int   n;
    int   a;
    rec_t e;
    n = 0;
    a = int'(addr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    #1;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL req_accept: addr=%h not accepted within 200 cycles", addr);
    end else begin
      e.cyc = cyc + 1;
      if (m_fault(sz, a)) begin e.rdata = 32'd0; e.fault = 1'b1; end
      else if (we) begin e.rdata = 32'd0; e.fault = 1'b0; m_store(sz, a, wd); end
      else begin e.rdata = m_load(sz, uns, a); e.fault = 1'b0; end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 1000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_fault !== 1'b0) begin errors++; $display("FAIL rst_rsp_fault: got %b want 0", bus.rsp_fault); end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL rst_fault_count: got %0d want 0", fault_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] want [6];
    want = '{32'h0, 32'hFFFF_FF80, 32'h0, 32'h0000_007F, 32'h0000_0001, 32'h0000_0080};
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_7F01);
    for (int i = 0; i < 4; i++) do_req(1'b0, 2'd0, 1'b0, 32'h10 + i, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    wait_got(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL byte_lanes[%0d]: missing response want %h", i, want[i]); end
      else if (got_q[i].rdata !== want[i] || got_q[i].fault !== 1'b0) begin
        errors++; $display("FAIL byte_lanes[%0d]: got %h/%b want %h/0", i, got_q[i].rdata, got_q[i].fault, want[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_half_store();
    logic [31:0] want [6];
    want = '{32'h0, 32'h0, 32'h1111_BEEF, 32'hFFFF_BEEF, 32'h0000_BEEF, 32'h0000_1111};
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_1111);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hA5A5_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    wait_got(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL half_store[%0d]: missing response want %h", i, want[i]); end
      else if (got_q[i].rdata !== want[i] || got_q[i].fault !== 1'b0) begin
        errors++; $display("FAIL half_store[%0d]: got %h/%b want %h/0", i, got_q[i].rdata, got_q[i].fault, want[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_faults();
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, BYTES, 32'h0);
    wait_got(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL fault_rsp[%0d]: missing response want 0/1", i); end
      else if (got_q[i].rdata !== 32'd0 || got_q[i].fault !== 1'b1) begin
        errors++; $display("FAIL fault_rsp[%0d]: got %h/%b want 0/1", i, got_q[i].rdata, got_q[i].fault);
      end
    end
    checks++; if (fault_count !== 8'd4) begin errors++; $display("FAIL fault_count4: got %0d want 4", fault_count); end
    got_q.delete(); exp_q.delete();
    // Faulted stores aimed at (or aliasing onto) word 0x10 must leave it alone.
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF);
    do_req(1'b1, 2'd0, 1'b0, BYTES + 32'h10, 32'h55);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_got(3);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL fault_store_count: got %0d want 3", got_q.size()); end
    else if (got_q[0].fault !== 1'b1 || got_q[1].fault !== 1'b1 || got_q[2].rdata !== 32'h8000_7F01) begin
      errors++; $display("FAIL fault_no_write: got %b %b %h want 1 1 80007f01", got_q[0].fault, got_q[1].fault, got_q[2].rdata);
    end
    checks++; if (fault_count !== 8'd6) begin errors++; $display("FAIL fault_count6: got %0d want 6", fault_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          first;
    for (int w = 0; w < 64; w++) do_req(1'b1, 2'd2, 1'b0, 32'h100 + 4 * w, $urandom);
    first = exp_q.size();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) addr = BYTES + $urandom_range(0, 255);
      else addr = 32'h100 + $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      do_req($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), addr, $urandom);
    end
    checks++;
    if (exp_q[exp_q.size() - 1].cyc - exp_q[first].cyc != 79) begin
      errors++; $display("FAIL rand_throughput: got span %0d want 79", exp_q[exp_q.size() - 1].cyc - exp_q[first].cyc);
    end
    wait_got(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].fault !== exp_q[i].fault) begin
        errors++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", i, got_q[i].rdata, got_q[i].fault, exp_q[i].rdata, exp_q[i].fault);
      end
      checks++;
      if (got_q[i].cyc - exp_q[i].cyc != LAT) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, got_q[i].cyc - exp_q[i].cyc, LAT);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int last;
    fork
      begin
        for (int i = 0; i < 8; i++) do_req(1'b0, 2'd2, 1'b0, 32'h100 + 4 * i, 32'h0);
      end
      begin
        repeat (5) @(negedge clk);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          #1;
          checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop[%0d]: got %b want 0", k, bus.req_ready); end
          checks++;
          if (exp_q.size() <= got_q.size()) begin errors++; $display("FAIL b2b_hold[%0d]: no pending response", k); end
          else if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[got_q.size()].rdata) begin
            errors++; $display("FAIL b2b_hold[%0d]: got %b/%h want 1/%h", k, bus.rsp_valid, bus.rsp_rdata, exp_q[got_q.size()].rdata);
          end
          @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
      end
    join
    wait_got(8);
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].rdata !== exp_q[i].rdata || got_q[i].fault !== 1'b0) begin
        errors++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/0", i, got_q[i].rdata, got_q[i].fault, exp_q[i].rdata);
      end
    end
    last = got_q.size() - 1;
    checks++;
    if (got_q.size() == 0 || got_q[0].cyc - exp_q[0].cyc != LAT) begin
      errors++; $display("FAIL b2b_lat_first: got %0d want %0d", got_q.size() ? got_q[0].cyc - exp_q[0].cyc : -1, LAT);
    end
    checks++;
    if (last < 0 || got_q[last].cyc - exp_q[last].cyc != LAT) begin
      errors++; $display("FAIL b2b_lat_last: got %0d want %0d", last >= 0 ? got_q[last].cyc - exp_q[last].cyc : -1, LAT);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_saturate();
    int nf;
    for (int i = 0; i < 300; i++) do_req(1'b0, 2'd3, 1'b0, 32'($urandom_range(0, 255)), 32'h0);
    wait_got(300);
    nf = 0;
    foreach (got_q[i]) if (got_q[i].fault === 1'b1) nf++;
    checks++; if (nf != 300) begin errors++; $display("FAIL sat_faults: got %0d want 300", nf); end
    checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", fault_count); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_inflight();
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rip_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_fault !== 1'b0) begin
      errors++; $display("FAIL rip_rsp: got %b/%h/%b want 0/0/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault);
    end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL rip_fault_count: got %0d want 0", fault_count); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rip_dropped: got %0d responses want 0", got_q.size()); end
    exp_q.delete(); got_q.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0].rdata !== 32'h8000_7F01) begin
      errors++; $display("FAIL rip_no_commit: got %h want 80007f01", got_q.size() ? got_q[0].rdata : 32'hX);
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
    test_reset();
    test_byte_lanes();
    test_half_store();
    test_faults();
    test_random();
    test_back_to_back();
    test_saturate();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised byte-addressable data memory for the MIPS datapath, replacing the word-only data memory with sized, big-endian accesses: byte/half/word loads with sign or zero extension and byte-lane stores. Requests enter through a valid/ready handshake, reads return after a configurable pipeline latency, and misaligned or out-of-range accesses are reported as faults instead of corrupting memory. Sits between the MEM stage and the load/store unit.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥4
- READ_LAT, 1, cycles from request accept to response; legal 1..4
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; transfer when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request faulted
- fault_count  out  8  saturating count of faulted requests

## Operation
- Byte order big-endian: offset 0 = bits [31:24], offset 3 = [7:0]; half offset 0 = [31:16], offset 2 = [15:0].
- Word index = req_addr[AW-1:2], AW = log2(DEPTH_WORDS)+2.
- Fault if: req_size==11; half with addr[0]==1; word with addr[1:0]!=0; req_addr ≥ DEPTH_WORDS*4. Faulted requests never modify memory.
- Store: written at the accept edge, only the addressed lanes; other lanes unchanged.
- Load: word read at the accept edge, lane extracted and extended at the output.
- Every accepted request (load, store, fault) yields exactly one response, in order.
- fault_count increments on each accepted faulted request, holds at 255.
- Memory array not reset; contents undefined until written.

## Timing
- Pipeline of READ_LAT stages, each with a valid bit; stage 1 loaded on accept.
- stall = rsp_valid && !rsp_ready; req_ready = !stall && rst_n.
- No stall: response appears exactly READ_LAT cycles after the accept edge; one request per cycle sustained.
- Stall freezes every stage; a response holds rsp_rdata/rsp_fault stable until rsp_ready.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data; a load and store cannot be accepted in the same cycle (single port).
- Reset (rst_n low at an edge): all stage valids, rsp_valid, rsp_rdata, rsp_fault, fault_count cleared to 0; in-flight requests dropped without response; no store commits while rst_n low.
- Reset outputs: req_ready 0 during reset, 1 the first cycle after.

## Structure
- Package dmem_pkg: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD), response struct {rdata, fault}, fault-check function.
- Sub-module dmem_lane_align: combinational load extract/extend and store lane-mask/data merge, both big-endian; instantiated once for each direction or as one module with two outputs.
- Top holds array, pipeline stages, handshake, counter.

## Test plan
- Store word 0x8000_7F01 at 0x10, load bytes at 0x10..0x13 signed -> 0xFFFF_FF80, 0x0000_0000, 0x0000_007F, 0x0000_0001; unsigned offset 0 -> 0x0000_0080.
- Store half 0xBEEF at 0x22 over word 0x1111_1111 at 0x20 -> word load returns 0x1111_BEEF; signed half at 0x22 -> 0xFFFF_BEEF.
- Word load at 0x06, half at 0x01, size 11, address DEPTH_WORDS*4 -> four responses with rsp_fault=1, rdata 0, fault_count 4, memory unchanged.
- READ_LAT=3, back-to-back loads, rsp_ready low 2 cycles mid-stream -> req_ready drops, no response lost/duplicated, order preserved, latency 3 otherwise.
- 300 faulted requests -> fault_count saturates at 255.
- rst_n low with 2 loads in flight and a store presented -> no responses, store not committed, all outputs 0.
